// File: rtl/mb_rtu_frame_tx.sv
// Modbus RTU master request-frame serialiser: streams id/fun/addr/num[/payload] + CRC16
// over a ready/valid byte interface and enforces the inter-frame silent gap.
module mb_rtu_frame_tx #(
  parameter int MAX_REGS   = 8,
  parameter int GAP_CYCLES = 200521,
  parameter int CNT_W      = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              slave_id,
  input  logic [7:0]              fun,
  input  logic [15:0]             mb_addr,
  input  logic [15:0]             mb_num,
  input  logic [16*MAX_REGS-1:0]  wr_data,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    tx_done,
  output logic                    req_err
);

  localparam int IDX_W = $clog2(8 + 2*MAX_REGS);

  typedef enum logic [2:0] {IDLE, SEND, CRC_LO, CRC_HI, GAP} state_t;

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] r;
    r = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  state_t                 state_r, state_s;
  logic [IDX_W-1:0]       idx_r, idx_s, nidx_s, rel_s, last_s;
  logic [15:0]            crc_r, crc_s, word_s;
  logic [CNT_W-1:0]       gap_r, gap_s;
  logic                   tx_valid_r, valid_s, busy_r, busy_s, tx_done_r, done_s, req_err_r, err_s;
  logic [7:0]             tx_data_r, data_s, nbyte_s;
  logic                   ok_s, latch_s, hs_s, wm_s;
  logic [7:0]             id_r, fun_r;
  logic [15:0]            addr_r, num_r;
  logic [16*MAX_REGS-1:0] wdata_r;

  assign tx_valid = tx_valid_r;
  assign tx_data  = tx_data_r;
  assign busy     = busy_r;
  assign tx_done  = tx_done_r;
  assign req_err  = req_err_r;

  // Request validation against the supported function codes.
  always_comb begin
    ok_s = 1'b0;
    case (fun)
      8'h01, 8'h02, 8'h03, 8'h04, 8'h06: ok_s = 1'b1;
      8'h10:   ok_s = (mb_num != 16'h0000) && (mb_num <= 16'(MAX_REGS));
      default: ok_s = 1'b0;
    endcase
  end

  // Next body byte to present, derived from the latched request and the index after the current one.
  always_comb begin
    wm_s   = (fun_r == 8'h10);
    last_s = wm_s ? (IDX_W'(6) + {num_r[IDX_W-2:0], 1'b0}) : IDX_W'(5);
    nidx_s = idx_r + IDX_W'(1);
    rel_s  = nidx_s - IDX_W'(7);
    word_s = 16'h0000;
    for (int i = 0; i < MAX_REGS; i++) begin
      if (rel_s[IDX_W-1:1] == (IDX_W-1)'(i)) begin
        word_s = wdata_r[16*i +: 16];
      end else begin
        word_s = word_s;
      end
    end
    case (nidx_s)
      IDX_W'(1): nbyte_s = fun_r;
      IDX_W'(2): nbyte_s = addr_r[15:8];
      IDX_W'(3): nbyte_s = addr_r[7:0];
      IDX_W'(4): nbyte_s = num_r[15:8];
      IDX_W'(5): nbyte_s = num_r[7:0];
      IDX_W'(6): nbyte_s = {num_r[6:0], 1'b0};
      default:   nbyte_s = nidx_s[0] ? word_s[15:8] : word_s[7:0];
    endcase
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    crc_s   = crc_r;
    gap_s   = gap_r;
    valid_s = tx_valid_r;
    data_s  = tx_data_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    latch_s = 1'b0;
    hs_s    = tx_valid_r & tx_ready;
    case (state_r)
      IDLE: begin
        if (start && ok_s) begin
          latch_s = 1'b1;
          state_s = SEND;
          idx_s   = '0;
          crc_s   = 16'hFFFF;
          valid_s = 1'b1;
          data_s  = slave_id;
          busy_s  = 1'b1;
        end else if (start) begin
          err_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (hs_s) begin
          crc_s = crc16_upd(crc_r, tx_data_r);
          if (idx_r == last_s) begin
            state_s = CRC_LO;
            data_s  = crc_s[7:0];
          end else begin
            idx_s  = nidx_s;
            data_s = nbyte_s;
          end
        end else begin
          state_s = SEND;
        end
      end
      CRC_LO: begin
        if (hs_s) begin
          state_s = CRC_HI;
          data_s  = crc_r[15:8];
        end else begin
          state_s = CRC_LO;
        end
      end
      CRC_HI: begin
        if (hs_s) begin
          state_s = GAP;
          done_s  = 1'b1;
          valid_s = 1'b0;
          data_s  = 8'h00;
          gap_s   = '0;
        end else begin
          state_s = CRC_HI;
        end
      end
      GAP: begin
        if (gap_r == CNT_W'(GAP_CYCLES - 1)) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          gap_s = gap_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        data_s  = 8'h00;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      crc_r      <= 16'hFFFF;
      gap_r      <= '0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      tx_done_r  <= 1'b0;
      req_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      crc_r      <= crc_s;
      gap_r      <= gap_s;
      tx_valid_r <= valid_s;
      tx_data_r  <= data_s;
      busy_r     <= busy_s;
      tx_done_r  <= done_s;
      req_err_r  <= err_s;
    end
  end

  // Request capture so the caller may change its inputs once the frame has started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r    <= 8'h00;
      fun_r   <= 8'h00;
      addr_r  <= 16'h0000;
      num_r   <= 16'h0000;
      wdata_r <= '0;
    end else if (latch_s) begin
      id_r    <= slave_id;
      fun_r   <= fun;
      addr_r  <= mb_addr;
      num_r   <= mb_num;
      wdata_r <= wr_data;
    end
  end

endmodule

// File: doc/mb_rtu_frame_tx.md
Name: mb_rtu_frame_tx

Overview:
Parametrised Modbus RTU master request-frame generator. It serialises a complete request into a byte stream with a ready/valid handshake toward the UART transmitter. CRC16 is computed inline and appended low byte first. The block supports read (0x01–0x04), write-single (0x06) and write-multiple (0x10) function codes, and enforces the RTU 3.5-character silent interval between frames. It sits between the Modbus master control FSM and the uart_tx byte sender.

Parameters:
MAX_REGS, 8, maximum register count for function 0x10; sets payload bus width to 16*MAX_REGS.
GAP_CYCLES, 200521, clk cycles of enforced silence after each frame (3.5 chars × 11 bits at 9600 baud, 50 MHz).
CNT_W, 18, width of the gap counter; must satisfy 2^CNT_W > GAP_CYCLES.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request pulse
slave_id  in  8  slave address byte
fun  in  8  function code
mb_addr  in  16  starting register or coil address
mb_num  in  16  quantity for 0x01–0x04 and 0x10; register value for 0x06
wr_data  in  16*MAX_REGS  0x10 payload; register k occupies bits [16k+15:16k]
tx_valid  out  1  tx_data is valid
tx_data  out  8  current frame byte
tx_ready  in  1  UART accepts the byte when tx_valid && tx_ready
busy  out  1  frame in progress or gap running
tx_done  out  1  one-cycle pulse on acceptance of the last CRC byte
req_err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset values: tx_valid=0, tx_data=0x00, busy=0, tx_done=0, req_err=0. CRC register=0xFFFF, gap counter=0, state=IDLE.
- A reset mid-frame aborts immediately; no partial-frame recovery.
- start is sampled only in IDLE; start while busy=1 is ignored (no error).
- On an accepted start, all inputs are latched, including wr_data. busy rises the next cycle and tx_valid rises with the first byte one cycle after start.
- Rejection (IDLE, start=1):
  - fun not in {01,02,03,04,06,10}, or
  - fun=0x10 with mb_num=0 or mb_num>MAX_REGS.
  - Response: req_err pulses the next cycle, the block stays IDLE, busy stays 0.
- States:
  - IDLE: start accepted → SEND; start rejected → stay IDLE.
  - SEND: present bytes in order; advance on each handshake. Last body byte accepted → CRC_LO.
  - CRC_LO: present crc[7:0] → CRC_HI on handshake.
  - CRC_HI: present crc[15:8]; on handshake pulse tx_done, drop tx_valid → GAP.
  - GAP: count GAP_CYCLES cycles → IDLE; busy deasserts on entry to IDLE.
- Byte order:
  - Read functions and 0x06: id, fun, addr_hi, addr_lo, num_hi, num_lo (8 bytes including CRC).
  - 0x10: id, fun, addr_hi, addr_lo, num_hi, num_lo, bytecount=2*num[7:0], then for k=0..num-1: reg_k_hi, reg_k_lo (9+2N bytes including CRC).
- Byte index counter: wide enough for 7+2*MAX_REGS; it resets to 0 on each accepted start.
- CRC16/Modbus:
  - init 0xFFFF at frame start; reflected polynomial 0xA001, 8 unrolled shift/xor steps.
  - The CRC updates in the cycle a body byte handshakes; CRC bytes are excluded.
- tx_valid/tx_data stability: once tx_valid=1, tx_data must hold until tx_ready. tx_ready may stay low indefinitely; there is no timeout and no byte is ever dropped.
- Back-to-back handshakes (tx_ready held high) give one byte per cycle.
- tx_done and the start of GAP occur in the same cycle; a start arriving during GAP is ignored.

Test Plan:
1. Read 0x03: slave 0x01, addr 0x0000, num 0x000A, tx_ready=1 → bytes 01 03 00 00 00 0A C5 CD; tx_done on the 8th handshake; busy low exactly GAP_CYCLES after it.
2. Write single 0x06: slave 0x01, addr 0x0001, value 0x0003, with random tx_ready stalls → bytes 01 06 00 01 00 03 98 0B; tx_data is stable during every stall.
3. Write multiple 0x10: num=2, reg0=0x000A, reg1=0x0102 → 01 10 00 01 00 02 04 00 0A 01 02 followed by a CRC matching the bench model (low byte first); 13 bytes total. Also run num=MAX_REGS and check the 9+2*MAX_REGS byte count.
4. Rejects: fun=0x05; fun=0x10 with num=0; fun=0x10 with num=MAX_REGS+1 → req_err single pulse each time, tx_valid never rises, busy=0.
5. start pulsed mid-frame and again during GAP → ignored; the frame in progress is unchanged. start one cycle after busy falls → the new frame begins.
6. Assert rst_n low mid-frame (byte 4 pending, tx_ready=0) → all outputs return to reset values immediately. After release, a fresh 0x03 frame is correct and starts without a gap.
